// File: rtl/seg_write_back_reg.sv
// MEM/WB pipeline register with stall/flush, write-back source selection, load
// byte/half/word extraction with sign/zero extension, and a retired-instruction counter.
module seg_write_back_reg #(
  parameter int unsigned LEN        = 32,
  parameter int unsigned NB_ADDR    = 5,
  parameter int unsigned NB_CTRL_WB = 6,
  parameter int unsigned NB_CNT     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [LEN-1:0]        i_read_data,
  input  logic [LEN-1:0]        i_alu_result,
  input  logic [LEN-1:0]        i_pc_link,
  input  logic [1:0]            i_byte_offset,
  input  logic [NB_ADDR-1:0]    i_write_register,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  output logic                  o_RegWrite,
  output logic [LEN-1:0]        o_write_data,
  output logic [NB_ADDR-1:0]    o_write_register,
  output logic                  o_valid,
  output logic                  o_misaligned,
  output logic [NB_CNT-1:0]     o_retired_count
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  logic               valid_q, valid_d;
  logic               regwrite_q, regwrite_d;
  wb_sel_e            wbsel_q, wbsel_d;
  logic [1:0]         ldsize_q, ldsize_d;
  logic               ldu_q, ldu_d;
  logic [1:0]         off_q, off_d;
  logic [LEN-1:0]     rdata_q, rdata_d;
  logic [LEN-1:0]     alu_q, alu_d;
  logic [LEN-1:0]     link_q, link_d;
  logic [NB_ADDR-1:0] wreg_q, wreg_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    wbsel_d    = wbsel_q;
    ldsize_d   = ldsize_q;
    ldu_d      = ldu_q;
    off_d      = off_q;
    rdata_d    = rdata_q;
    alu_d      = alu_q;
    link_d     = link_q;
    wreg_d     = wreg_q;
    cnt_d      = cnt_q;
    if (i_flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      wbsel_d    = WB_ALU;
      ldsize_d   = '0;
      ldu_d      = 1'b0;
      off_d      = '0;
      rdata_d    = '0;
      alu_d      = '0;
      link_d     = '0;
      wreg_d     = '0;
    end else if (!i_stall) begin
      valid_d    = i_valid;
      regwrite_d = i_ctrl_wb_bus[5] & i_valid;
      wbsel_d    = wb_sel_e'(i_ctrl_wb_bus[4:3]);
      ldsize_d   = i_ctrl_wb_bus[2:1];
      ldu_d      = i_ctrl_wb_bus[0];
      off_d      = i_byte_offset;
      rdata_d    = i_read_data;
      alu_d      = i_alu_result;
      link_d     = i_pc_link;
      wreg_d     = i_write_register;
      cnt_d      = cnt_q + NB_CNT'(i_valid);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wbsel_q    <= WB_ALU;
      ldsize_q   <= '0;
      ldu_q      <= 1'b0;
      off_q      <= '0;
      rdata_q    <= '0;
      alu_q      <= '0;
      link_q     <= '0;
      wreg_q     <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      wbsel_q    <= wbsel_d;
      ldsize_q   <= ldsize_d;
      ldu_q      <= ldu_d;
      off_q      <= off_d;
      rdata_q    <= rdata_d;
      alu_q      <= alu_d;
      link_q     <= link_d;
      wreg_q     <= wreg_d;
      cnt_q      <= cnt_d;
    end
  end

  // Little-endian lane select: shift the addressed lane down to bit 0.
  logic [7:0]     byte_val;
  logic [15:0]    half_val;
  logic [LEN-1:0] load_val;
  logic           misaligned;

  always_comb begin
    byte_val = 8'(rdata_q >> {off_q, 3'b000});
    half_val = 16'(rdata_q >> {off_q[1], 4'b0000});
    case (ldsize_q)
      2'b00:   load_val = {{(LEN-8){~ldu_q & byte_val[7]}}, byte_val};
      2'b01:   load_val = {{(LEN-16){~ldu_q & half_val[15]}}, half_val};
      default: load_val = rdata_q;
    endcase
    case (wbsel_q)
      WB_LOAD: o_write_data = load_val;
      WB_LINK: o_write_data = link_q;
      default: o_write_data = alu_q;
    endcase
    misaligned = valid_q & (wbsel_q == WB_LOAD) &
                 (((ldsize_q == 2'b01) & off_q[0]) | (ldsize_q[1] & (off_q != 2'b00)));
  end

  assign o_misaligned     = misaligned;
  assign o_RegWrite       = regwrite_q & valid_q & ~misaligned & (wreg_q != '0);
  assign o_write_register = wreg_q;
  assign o_valid          = valid_q;
  assign o_retired_count  = cnt_q;

endmodule

// File: tb/tb_seg_write_back_reg.sv
// Bench for seg_write_back_reg: table-driven vectors plus stall/flush/reset/wrap
// sequences, expected results queued at drive time and checked one cycle later.
module tb_seg_write_back_reg;

  localparam int unsigned NB_CNT = 4;

  logic        clk = 1'b0;
  logic        rst, valid, stall, flush;
  logic [31:0] rdata, alu, pc;
  logic [1:0]  off;
  logic [4:0]  wreg;
  logic [5:0]  ctrl;
  logic        o_rw, o_v, o_mis;
  logic [31:0] o_data;
  logic [4:0]  o_reg;
  logic [NB_CNT-1:0] o_cnt;

  seg_write_back_reg #(.LEN(32), .NB_ADDR(5), .NB_CTRL_WB(6), .NB_CNT(NB_CNT)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_read_data(rdata), .i_alu_result(alu), .i_pc_link(pc), .i_byte_offset(off),
    .i_write_register(wreg), .i_ctrl_wb_bus(ctrl),
    .o_RegWrite(o_rw), .o_write_data(o_data), .o_write_register(o_reg),
    .o_valid(o_v), .o_misaligned(o_mis), .o_retired_count(o_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, valid, stall, flush;
    logic [31:0] rdata, alu, pc;
    logic [1:0] off;
    logic [4:0] wreg;
    logic [5:0] ctrl;
    logic e_rw;
    logic [31:0] e_data;
    logic [4:0] e_reg;
    logic e_v, e_mis;
  } vec_t;

  typedef struct {
    logic rw;
    logic [31:0] data;
    logic [4:0] rg;
    logic v, mis;
    logic [NB_CNT-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [NB_CNT-1:0] cnt_m = '0;
  vec_t tbl[14];

  function automatic vec_t mk(input logic r, v, s, f, input logic [31:0] rd, a, p,
                              input logic [1:0] o, input logic [4:0] w, input logic [5:0] c,
                              input logic erw, input logic [31:0] ed, input logic [4:0] er,
                              input logic ev, em);
    vec_t t;
    t.rst = r; t.valid = v; t.stall = s; t.flush = f;
    t.rdata = rd; t.alu = a; t.pc = p; t.off = o; t.wreg = w; t.ctrl = c;
    t.e_rw = erw; t.e_data = ed; t.e_reg = er; t.e_v = ev; t.e_mis = em;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    @(negedge clk);
    rst = t.rst; valid = t.valid; stall = t.stall; flush = t.flush;
    rdata = t.rdata; alu = t.alu; pc = t.pc; off = t.off; wreg = t.wreg; ctrl = t.ctrl;
    if (t.rst) cnt_m = '0;
    else if (!t.flush && !t.stall && t.valid) cnt_m = cnt_m + 1'b1;
    e.rw = t.e_rw; e.data = t.e_data; e.rg = t.e_reg; e.v = t.e_v; e.mis = t.e_mis;
    e.cnt = cnt_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      chk("RegWrite", {31'd0, o_rw}, {31'd0, e.rw});
      chk("write_data", o_data, e.data);
      chk("write_register", {27'd0, o_reg}, {27'd0, e.rg});
      chk("valid", {31'd0, o_v}, {31'd0, e.v});
      chk("misaligned", {31'd0, o_mis}, {31'd0, e.mis});
      chk("retired_count", {28'd0, o_cnt}, {28'd0, e.cnt});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0;
    rdata = '0; alu = '0; pc = '0; off = '0; wreg = '0; ctrl = '0;

    //           rst v s f  rdata         alu           pc            off   rd  ctrl        rw data          reg v mis
    tbl[0]  = mk(0, 1,0,0, 32'h0,        32'h1234,     32'h0,        2'd0, 5,  6'b100000, 1, 32'h00001234, 5, 1, 0);
    tbl[1]  = mk(0, 1,0,0, 32'h80FF7F01, 32'h0,        32'h0,        2'd2, 6,  6'b101000, 1, 32'hFFFFFFFF, 6, 1, 0);
    tbl[2]  = mk(0, 1,0,0, 32'h80FF7F01, 32'h0,        32'h0,        2'd2, 6,  6'b101001, 1, 32'h000000FF, 6, 1, 0);
    tbl[3]  = mk(0, 1,0,0, 32'h80FF7F01, 32'h0,        32'h0,        2'd3, 8,  6'b101000, 1, 32'hFFFFFF80, 8, 1, 0);
    tbl[4]  = mk(0, 1,0,0, 32'h80FF7F01, 32'h0,        32'h0,        2'd0, 8,  6'b101000, 1, 32'h00000001, 8, 1, 0);
    tbl[5]  = mk(0, 1,0,0, 32'h80017F01, 32'h0,        32'h0,        2'd2, 10, 6'b101010, 1, 32'hFFFF8001, 10, 1, 0);
    tbl[6]  = mk(0, 1,0,0, 32'h80017F01, 32'h0,        32'h0,        2'd0, 10, 6'b101011, 1, 32'h00007F01, 10, 1, 0);
    tbl[7]  = mk(0, 1,0,0, 32'h80017F01, 32'h0,        32'h0,        2'd1, 11, 6'b101010, 0, 32'h00007F01, 11, 1, 1);
    tbl[8]  = mk(0, 1,0,0, 32'h80017F01, 32'h0,        32'h0,        2'd0, 12, 6'b101100, 1, 32'h80017F01, 12, 1, 0);
    tbl[9]  = mk(0, 1,0,0, 32'h80017F01, 32'h0,        32'h0,        2'd2, 12, 6'b101110, 0, 32'h80017F01, 12, 1, 1);
    tbl[10] = mk(0, 1,0,0, 32'h0,        32'hDEAD,     32'h00400010, 2'd0, 31, 6'b110000, 1, 32'h00400010, 31, 1, 0);
    tbl[11] = mk(0, 1,0,0, 32'h0,        32'h5555,     32'h0,        2'd0, 0,  6'b100000, 0, 32'h00005555, 0, 1, 0);
    tbl[12] = mk(0, 1,0,0, 32'hFFFFFFFF, 32'h0BAD,     32'h77,       2'd0, 3,  6'b111000, 1, 32'h00000BAD, 3, 1, 0);
    tbl[13] = mk(0, 0,0,0, 32'h0,        32'h4321,     32'h0,        2'd0, 4,  6'b100000, 0, 32'h00004321, 4, 0, 0);

    for (int i = 0; i < 3; i++)
      step(mk(1, 1,0,0, 32'hFFFF, 32'hFFFF, 32'hFFFF, 2'd1, 7, 6'b100000, 0, 32'h0, 0, 0, 0));
    foreach (tbl[i]) step(tbl[i]);
    step(mk(0, 1,0,0, 32'h0, 32'h1111, 32'h0, 2'd0, 7, 6'b000000, 0, 32'h00001111, 7, 1, 0));

    // stall with changing inputs: outputs and count frozen
    step(mk(0, 1,0,0, 32'h0, 32'hABCD, 32'h0, 2'd0, 9, 6'b100000, 1, 32'h0000ABCD, 9, 1, 0));
    for (int i = 0; i < 3; i++)
      step(mk(0, 1,1,0, $urandom, $urandom, $urandom, 2'($urandom), 5'($urandom), 6'($urandom),
              1, 32'h0000ABCD, 9, 1, 0));
    // stall+flush: flush wins, count unchanged
    step(mk(0, 1,1,1, 32'h1, 32'h2, 32'h3, 2'd0, 9, 6'b100000, 0, 32'h0, 0, 0, 0));

    // reset during a stalled load
    step(mk(0, 1,0,0, 32'h0, 32'h9999, 32'h0, 2'd0, 2, 6'b100000, 1, 32'h00009999, 2, 1, 0));
    step(mk(1, 1,1,0, 32'h5, 32'h6, 32'h7, 2'd0, 2, 6'b100000, 0, 32'h0, 0, 0, 0));

    // counter wrap: 15 loads reach 2^NB_CNT-1, the 16th wraps to 0
    for (int i = 1; i <= 16; i++)
      step(mk(0, 1,0,0, 32'h0, 32'(i), 32'h0, 2'd0, 1, 6'b100000, 1, 32'(i), 1, 1, 0));
    chk("wrap_count", {28'd0, o_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
